// File: rtl/bram_stream_reader.sv
// Read-side controller for the dual-port sample buffer: prefetches stored bytes
// through the registered read port into a 2-entry skid and streams them out
// over valid/ready. Optional underrun counter enabled by BRAM_READER_UNDERRUN_EN.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  empty,
  output logic [15:0]           underrun_count
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic                  inflight;
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic [DATA_WIDTH-1:0] q0, q1;
  logic                  pop, issue;

  assign fill       = wr_ptr - rd_ptr;
  assign empty      = (fill == '0);
  assign rd_addr    = rd_ptr[ADDR_WIDTH-1:0];
  assign dout       = q0;
  assign dout_valid = (occ != 2'd0);
  assign pop        = dout_valid & dout_ready;

  // The in-flight byte lands this cycle, so it already counts as occupancy;
  // this caps prefetch at two bytes ahead of the consumer.
  assign occ_nxt = occ - {1'b0, pop} + {1'b0, inflight};
  assign issue   = !empty && (occ_nxt < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      q0       <= '0;
      q1       <= '0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
      occ      <= occ_nxt;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) q0 <= rd_data;
          else             q1 <= rd_data;
        end
        2'b01: q0 <= q1;
        2'b11: begin
          if (occ == 2'd1) q0 <= rd_data;
          else begin
            q0 <= q1;
            q1 <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRAM_READER_UNDERRUN_EN
  logic        popped;
  logic [15:0] ucnt;

  // Starvation only counts once the stream has actually started.
  always_ff @(posedge clk) begin
    if (reset) begin
      popped <= 1'b0;
      ucnt   <= '0;
    end else begin
      if (pop) popped <= 1'b1;
      if (popped && dout_ready && !dout_valid && (ucnt != 16'hFFFF))
        ucnt <= ucnt + 16'd1;
    end
  end

  assign underrun_count = ucnt;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the 2k x 8 dual-port packet/sample buffer. Drives the buffer's registered read port (`dpra`/`dpo`), tracks the writer's pointer, and streams stored bytes out over a valid/ready interface at up to one byte per clock. The buffer writer sits on the other port; this block returns its read pointer to the writer for full detection.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: buffer address width (depth 2^ADDR_WIDTH).
- `DATA_WIDTH`, 8: byte width.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_ptr`  in  ADDR_WIDTH+1  writer pointer; MSB is the wrap bit. Advances on the same edge its byte is written.
- `rd_addr`  out  ADDR_WIDTH  registered address to the buffer `dpra`.
- `rd_data`  in  DATA_WIDTH  buffer `dpo`, valid one cycle after `rd_addr`.
- `rd_ptr`  out  ADDR_WIDTH+1  fetch pointer with wrap bit, returned to the writer.
- `dout`  out  DATA_WIDTH  stream data.
- `dout_valid`  out  1  stream valid.
- `dout_ready`  in  1  downstream ready.
- `fill`  out  ADDR_WIDTH+1  unfetched bytes in the buffer, `wr_ptr - rd_ptr` mod 2^(ADDR_WIDTH+1).
- `empty`  out  1  `fill == 0`.
- `underrun_count`  out  16  see Configuration.

## Operation
- `rd_addr` always equals `rd_ptr[ADDR_WIDTH-1:0]`.
- Fetch issue condition in a cycle: `!empty` and (output buffer occupancy + in-flight fetch) < 2, evaluated against the occupancy after this cycle's pop.
- On issue: `rd_ptr` increments at the edge and the in-flight flag is set; on the next cycle `rd_data` is captured into the output buffer.
- Output buffer: 2-entry FIFO (skid). Head drives `dout`; `dout_valid` = occupancy != 0. Pop on `dout_valid && dout_ready`.
- Capture and pop in the same cycle: occupancy unchanged, order preserved.
- `dout` holds its value while `dout_valid && !dout_ready`; never changes without a pop.
- Pointer arithmetic is modulo 2^(ADDR_WIDTH+1); `rd_addr` wraps from 2047 to 0 without a gap.
- `fill` = 2048 (full buffer) is legal; `fill` > 2048 is a writer error and is not checked.
- Bytes are emitted exactly once and in address order.

## Timing
- Reset values: `rd_ptr` 0, `rd_addr` 0, `dout` 0, `dout_valid` 0, in-flight 0, occupancy 0, `underrun_count` 0; `fill`/`empty` follow `wr_ptr`.
- Reset during operation: in-flight fetch and buffered bytes are discarded and output is 0 from the next cycle. The writer is reset by the same `reset`.
- Latency: `wr_ptr` advances in cycle N, the fetch issues in N, `rd_data` is valid in N+1, and `dout_valid` = 1 in N+2.
- Throughput: one byte per cycle sustained with `dout_ready` held high and `fill` > 0.
- Backpressure: at most 2 bytes are fetched beyond the consumer. With `dout_ready` low, at most 2 issues occur and then fetching stops.
- The writer may write the address just fetched on the following edge. The buffer is read-before-write, so the fetched byte is unaffected.

## Configuration
- `BRAM_READER_UNDERRUN_EN` defined: `underrun_count` is a saturating 16-bit counter, cleared by reset. It increments each cycle with `dout_ready && !dout_valid`, once at least one byte has been popped since reset. It saturates at 0xFFFF.
- Not defined: counter logic absent, `underrun_count` tied to 0.

## Test plan
- Reset, then write 0x41..0x44 (`wr_ptr` 0→4) with `dout_ready`=1 -> `dout_valid` first high 2 cycles after `wr_ptr`=1, bytes 0x41,0x42,0x43,0x44 on consecutive cycles, `rd_ptr`=4, `empty`=1.
- Preload 2048 bytes (`wr_ptr`=0x800), `dout_ready`=0 -> `fill`=2048 then 2046, `rd_ptr`=2, `dout` stable at byte 0. Release ready -> all 2048 bytes in order at 1/cycle.
- Start with `rd_ptr`=2046, write 4 bytes -> `rd_addr` 2046,2047,0,1; `rd_ptr` 0x7FE→0x802; data in order.
- Random `dout_ready` toggling over 10000 bytes -> no loss, duplication or reordering, and `dout` never changes while stalled.
- Assert `reset` with 2 bytes buffered and 1 in flight -> next cycle `dout_valid`=0, `dout`=0, `rd_ptr`=0.
- With macro: pop 1 byte, then hold ready high with the buffer empty for 5 cycles -> `underrun_count`=5. Without macro -> stays 0.
